// File: rtl/card_shoe.sv
// card_shoe: card source for the blackjack top. Random mode deals from a
// multi-deck shoe without replacement; modes 1..4 replay fixed deal scripts.
module card_shoe #(
    parameter int unsigned NUM_DECKS  = 1,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int unsigned SCRIPT_LEN = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] mode,
    input  logic       draw_req,
    input  logic       shuffle,
    output logic       card_valid,
    output logic [3:0] card_rank,
    output logic [5:0] card_value,
    output logic       busy,
    output logic [7:0] cards_left,
    output logic       shoe_empty,
    output logic       draw_err
);

    localparam int unsigned     PTR_W     = (SCRIPT_LEN > 1) ? $clog2(SCRIPT_LEN) : 1;
    localparam logic [4:0]      RANK_FULL = 5'(4 * NUM_DECKS);
    localparam logic [7:0]      SHOE_FULL = 8'(52 * NUM_DECKS);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(SCRIPT_LEN - 1);

    typedef enum logic {IDLE, SEARCH} state_t;

    state_t            state, state_nx;
    logic [15:0]       lfsr;
    logic [2:0]        mode_q;
    logic [PTR_W-1:0]  ptr;
    logic [13:1][4:0]  count;
    logic [3:0]        cand_q;
    logic [3:0]        look;
    logic [3:0]        look_nx;
    logic              scripted;
    logic              hit;
    logic              deal_rand;
    logic              deal_script;
    logic              go_search;
    logic              reject;

    // Script rows packed one nibble per deal position, position 0 in the low nibble.
    function automatic logic [3:0] script_rank(input logic [2:0] m, input logic [2:0] idx);
        logic [31:0] row;
        case (m)
            3'd1:    row = {4'd5, 4'd3, 4'd2, 4'd4, 4'd8, 4'd10, 4'd7, 4'd9};
            3'd2:    row = {4'd5, 4'd3, 4'd6, 4'd2, 4'd8, 4'd10, 4'd7, 4'd9};
            3'd3:    row = {4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd10, 4'd7, 4'd9};
            3'd4:    row = {4'd2, 4'd8, 4'd4, 4'd8, 4'd10, 4'd10, 4'd7, 4'd9};
            default: row = '0;
        endcase
        return row[{idx, 2'b00} +: 4];
    endfunction

    function automatic logic [5:0] rank_value(input logic [3:0] r);
        if (r == 4'd1)
            return 6'd11;
        else if (r >= 4'd11)
            return 6'd10;
        else
            return {2'b00, r};
    endfunction

    assign busy       = (state == SEARCH);
    assign shoe_empty = (cards_left == 8'd0);

    // Free-running Fibonacci LFSR, taps 16,14,13,11.
    always_ff @(posedge clk) begin
        if (!reset)
            lfsr <= LFSR_SEED;
        else
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next state and deal decisions; IDLE probes the LFSR rank, SEARCH walks the stored candidate.
    always_comb begin
        state_nx    = state;
        deal_rand   = 1'b0;
        deal_script = 1'b0;
        go_search   = 1'b0;
        reject      = 1'b0;
        scripted    = (mode_q >= 3'd1) && (mode_q <= 3'd4);
        look        = cand_q;
        if (state == IDLE)
            look = 4'(lfsr % 16'd13) + 4'd1;
        hit     = (count[look] != 5'd0);
        look_nx = (look == 4'd13) ? 4'd1 : look + 4'd1;
        if (shuffle) begin
            state_nx = IDLE;
        end else if (state == SEARCH) begin
            if (hit) begin
                deal_rand = 1'b1;
                state_nx  = IDLE;
            end
        end else if (draw_req) begin
            if (scripted) begin
                deal_script = 1'b1;
            end else if (cards_left == 8'd0) begin
                reject = 1'b1;
            end else if (hit) begin
                deal_rand = 1'b1;
            end else begin
                go_search = 1'b1;
                state_nx  = SEARCH;
            end
        end
    end

    // Shoe contents, script pointer, latched mode and registered card outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            card_valid <= 1'b0;
            card_rank  <= '0;
            card_value <= '0;
            draw_err   <= 1'b0;
            cards_left <= SHOE_FULL;
            ptr        <= '0;
            mode_q     <= mode;
            cand_q     <= 4'd1;
            for (int unsigned i = 1; i <= 13; i++)
                count[4'(i)] <= RANK_FULL;
        end else begin
            card_valid <= deal_rand | deal_script;
            draw_err   <= reject;
            if (go_search || state == SEARCH)
                cand_q <= look_nx;
            if (shuffle) begin
                cards_left <= SHOE_FULL;
                ptr        <= '0;
                mode_q     <= mode;
                for (int unsigned i = 1; i <= 13; i++)
                    count[4'(i)] <= RANK_FULL;
            end else if (deal_rand) begin
                card_rank   <= look;
                card_value  <= rank_value(look);
                count[look] <= count[look] - 5'd1;
                cards_left  <= cards_left - 8'd1;
            end else if (deal_script) begin
                card_rank  <= script_rank(mode_q, 3'(ptr));
                card_value <= rank_value(script_rank(mode_q, 3'(ptr)));
                ptr        <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_card_shoe.sv
// tb_card_shoe: directed scenarios plus LFSR-driven random draws checked
// against a card-count model of the shoe.
module tb_card_shoe;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] mode = 3'd0;
    logic       draw_req = 1'b0;
    logic       shuffle = 1'b0;
    logic       card_valid;
    logic [3:0] card_rank;
    logic [5:0] card_value;
    logic       busy;
    logic [7:0] cards_left;
    logic       shoe_empty;
    logic       draw_err;

    int total = 0;
    int bad   = 0;

    int          m_count [1:13];
    int          m_left;
    int          m_ptr;
    int          m_mode;
    logic [15:0] m_lfsr;
    int          tally [1:13];
    int script_tab [1:4][0:7] = '{'{9, 7, 10, 8, 4, 2, 3, 5},
                                  '{9, 7, 10, 8, 2, 6, 3, 5},
                                  '{9, 7, 10, 1, 2, 3, 4, 5},
                                  '{9, 7, 10, 10, 8, 4, 8, 2}};

    card_shoe #(.NUM_DECKS(1), .LFSR_SEED(16'hACE1), .SCRIPT_LEN(8)) dut (
        .clk(clk), .reset(reset), .mode(mode), .draw_req(draw_req), .shuffle(shuffle),
        .card_valid(card_valid), .card_rank(card_rank), .card_value(card_value),
        .busy(busy), .cards_left(cards_left), .shoe_empty(shoe_empty), .draw_err(draw_err)
    );

    always #5 clk = ~clk;

    // Reference LFSR: new bit is the parity of the tapped positions.
    always @(posedge clk) begin
        if (!reset)
            m_lfsr <= 16'hACE1;
        else
            m_lfsr <= {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1);
    end

    function automatic int exp_value(input int r);
        if (r == 1) return 11;
        if (r > 10) return 10;
        return r;
    endfunction

    function automatic int model_cand();
        return int'(m_lfsr % 16'd13) + 1;
    endfunction

    task automatic model_refill(input int m);
        for (int r = 1; r <= 13; r++) m_count[r] = 4;
        m_left = 52;
        m_ptr  = 0;
        m_mode = m;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_shuffle(input int m);
        mode    = 3'(m);
        shuffle = 1'b1;
        @(negedge clk);
        shuffle = 1'b0;
        model_refill(m);
    endtask

    task automatic do_script_draw(input string tag);
        int r;
        r     = script_tab[m_mode][m_ptr % 8];
        m_ptr = (m_ptr + 1) % 8;
        draw_req = 1'b1;
        @(negedge clk);
        draw_req = 1'b0;
        total++;
        if (card_valid !== 1'b1 || card_rank !== 4'(r) || card_value !== 6'(exp_value(r)) || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s: valid=%0b rank=%0d value=%0d busy=%0b, required valid=1 rank=%0d value=%0d busy=0",
                     tag, card_valid, card_rank, card_value, busy, r, exp_value(r));
        end
        @(negedge clk);
        total++;
        if (card_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_pulse: valid=%0b, required 0", tag, card_valid);
        end
    endtask

    task automatic do_rand_draw(input bit inject, output int rank);
        int r;
        int k;
        r = model_cand();
        k = 1;
        while (m_count[r] == 0 && k <= 13) begin
            r = (r % 13) + 1;
            k++;
        end
        draw_req = 1'b1;
        @(negedge clk);
        draw_req = 1'b0;
        for (int i = 1; i < k; i++) begin
            total++;
            if (card_valid !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL search_wait: cycle %0d valid=%0b busy=%0b, required valid=0 busy=1",
                         i, card_valid, busy);
            end
            draw_req = (inject && i == 1);
            @(negedge clk);
        end
        draw_req = 1'b0;
        total++;
        if (card_valid !== 1'b1 || busy !== 1'b0 || card_rank !== 4'(r) || card_value !== 6'(exp_value(r))) begin
            bad++;
            $display("FAIL rand_card: valid=%0b busy=%0b rank=%0d value=%0d, required valid=1 busy=0 rank=%0d value=%0d (latency %0d)",
                     card_valid, busy, card_rank, card_value, r, exp_value(r), k);
        end
        m_count[r]--;
        m_left--;
        total++;
        if (cards_left !== 8'(m_left) || shoe_empty !== (m_left == 0)) begin
            bad++;
            $display("FAIL cards_left: left=%0d empty=%0b, required left=%0d empty=%0b",
                     cards_left, shoe_empty, m_left, (m_left == 0));
        end
        rank = r;
    endtask

    task automatic deplete_aces();
        int r;
        int guard;
        guard = 0;
        while (m_count[1] > 0 && guard < 52) begin
            do_rand_draw(1'b0, r);
            idle($urandom_range(0, 2));
            guard++;
        end
    endtask

    task automatic wait_cand_one(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (model_cand() == 1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL wait_cand: candidate 1 never seen within 2000 cycles");
        end
    endtask

    task automatic check_reset_values(input string tag);
        total++;
        if (card_valid !== 1'b0 || card_rank !== 4'd0 || card_value !== 6'd0 || busy !== 1'b0 ||
            draw_err !== 1'b0 || cards_left !== 8'd52 || shoe_empty !== 1'b0) begin
            bad++;
            $display("FAIL %s: valid=%0b rank=%0d value=%0d busy=%0b err=%0b left=%0d empty=%0b, required 0 0 0 0 0 52 0",
                     tag, card_valid, card_rank, card_value, busy, draw_err, cards_left, shoe_empty);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        mode  = 3'd0;
        idle(2);
        check_reset_values("reset");
        reset = 1'b1;
        model_refill(0);
        idle(1);
    endtask

    task automatic test_script_simple();
        do_shuffle(1);
        for (int i = 0; i < 5; i++) begin
            do_script_draw("script_simple");
            idle(2);
        end
        total++;
        if (cards_left !== 8'd52 || shoe_empty !== 1'b0) begin
            bad++;
            $display("FAIL script_shoe: left=%0d empty=%0b, required 52 0", cards_left, shoe_empty);
        end
    endtask

    task automatic test_script_wrap();
        do_shuffle(3);
        for (int i = 0; i < 13; i++)
            do_script_draw("script_wrap");
    endtask

    task automatic test_random_shoe();
        int r;
        do_shuffle(0);
        for (int i = 1; i <= 13; i++) tally[i] = 0;
        for (int n = 0; n < 52; n++) begin
            do_rand_draw(1'b0, r);
            tally[r]++;
            idle($urandom_range(0, 3));
        end
        for (int i = 1; i <= 13; i++) begin
            total++;
            if (tally[i] != 4) begin
                bad++;
                $display("FAIL rank_tally: rank %0d dealt %0d times, required 4", i, tally[i]);
            end
        end
        total++;
        if (cards_left !== 8'd0 || shoe_empty !== 1'b1) begin
            bad++;
            $display("FAIL shoe_empty: left=%0d empty=%0b, required 0 1", cards_left, shoe_empty);
        end
        draw_req = 1'b1;
        @(negedge clk);
        draw_req = 1'b0;
        total++;
        if (draw_err !== 1'b1 || card_valid !== 1'b0) begin
            bad++;
            $display("FAIL empty_draw: err=%0b valid=%0b, required err=1 valid=0", draw_err, card_valid);
        end
        @(negedge clk);
        total++;
        if (draw_err !== 1'b0 || card_valid !== 1'b0) begin
            bad++;
            $display("FAIL empty_draw_pulse: err=%0b valid=%0b, required 0 0", draw_err, card_valid);
        end
    endtask

    task automatic test_search_busy();
        int  r;
        bit  ok;
        do_shuffle(0);
        deplete_aces();
        wait_cand_one(ok);
        if (ok && m_left > 0) begin
            do_rand_draw(1'b1, r);
            @(negedge clk);
            total++;
            if (card_valid !== 1'b0 || draw_err !== 1'b0 || busy !== 1'b0 || cards_left !== 8'(m_left)) begin
                bad++;
                $display("FAIL busy_ignore: valid=%0b err=%0b busy=%0b left=%0d, required 0 0 0 %0d",
                         card_valid, draw_err, busy, cards_left, m_left);
            end
        end
    endtask

    task automatic test_shuffle();
        bit ok;
        wait_cand_one(ok);
        if (ok && m_count[1] == 0 && m_left > 0) begin
            draw_req = 1'b1;
            @(negedge clk);
            draw_req = 1'b0;
            total++;
            if (busy !== 1'b1) begin
                bad++;
                $display("FAIL abort_busy: busy=%0b, required 1", busy);
            end
            do_shuffle(0);
            total++;
            if (busy !== 1'b0 || card_valid !== 1'b0 || cards_left !== 8'd52) begin
                bad++;
                $display("FAIL search_abort: busy=%0b valid=%0b left=%0d, required 0 0 52",
                         busy, card_valid, cards_left);
            end
            @(negedge clk);
            total++;
            if (card_valid !== 1'b0) begin
                bad++;
                $display("FAIL abort_late: valid=%0b, required 0", card_valid);
            end
        end
        draw_req = 1'b1;
        do_shuffle(0);
        draw_req = 1'b0;
        total++;
        if (card_valid !== 1'b0 || draw_err !== 1'b0 || cards_left !== 8'd52) begin
            bad++;
            $display("FAIL shuffle_wins: valid=%0b err=%0b left=%0d, required 0 0 52",
                     card_valid, draw_err, cards_left);
        end
        @(negedge clk);
        total++;
        if (card_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL shuffle_wins_late: valid=%0b busy=%0b, required 0 0", card_valid, busy);
        end
    endtask

    task automatic test_reset_mid_search();
        bit ok;
        deplete_aces();
        wait_cand_one(ok);
        if (ok && m_left > 0) begin
            draw_req = 1'b1;
            @(negedge clk);
            draw_req = 1'b0;
            total++;
            if (busy !== 1'b1) begin
                bad++;
                $display("FAIL reset_search_busy: busy=%0b, required 1", busy);
            end
            reset = 1'b0;
            mode  = 3'd0;
            @(negedge clk);
            reset = 1'b1;
            model_refill(0);
            check_reset_values("reset_mid_search");
            @(negedge clk);
            total++;
            if (card_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_late_card: valid=%0b, required 0", card_valid);
            end
        end
        do_shuffle(2);
        do_script_draw("mode_hold");
        do_script_draw("mode_hold");
        mode = 3'd1;
        for (int i = 0; i < 4; i++)
            do_script_draw("mode_hold");
    endtask

    initial begin
        test_reset();
        test_script_simple();
        test_script_wrap();
        test_random_shoe();
        test_search_busy();
        test_shuffle();
        test_reset_mid_search();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
